pipe_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one fixed-latency, non-stallable, reset-less pipeline
//  (e.g. a delaybyx-style delay chain or pipelined datapath) among N requesters.

---
 rtl/pipe_rr_sched.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_rr_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rr_sched.sv
// -----------------------------------------------------------------------------
// pipe_rr_sched
//
// Round-robin scheduler that shares one fixed-latency, non-stallable pipeline
// among N requesters. Each cycle it grants at most one requester and forwards
// that requester's operand into the pipe. It also carries the winner's ID and
// a valid bit through a tag pipeline that is exactly LATENCY stages deep. When
// the result comes out of the pipe, the tag is used to steer the response
// strobe back to the requester that issued the operation.
//
// Parameters
//   N        number of requesters (2..16)
//   WIDTH    operand / result width
//   LATENCY  latency of the shared pipe in clk cycles (>= 1)
//
// Ports
//   clk          clock; all state changes on posedge
//   rst          synchronous reset, active high
//   en           1 = new grants allowed, 0 = only drain operations in flight
//   req          per-requester request, held until granted
//   req_data     operand of requester i at [i*WIDTH +: WIDTH]
//   gnt          one-hot grant, combinational in the accept cycle
//   pipe_in      operand to the shared pipe (winner's data, otherwise 0)
//   pipe_in_vld  high when pipe_in carries a granted operation
//   pipe_out     result returning from the shared pipe
//   resp_vld     one-hot: the result for requester i is on resp_data this cycle
//   resp_data    pipe_out passed straight through; qualify it with resp_vld
//   busy         high while any operation is in flight, including the one
//                being granted this cycle
// -----------------------------------------------------------------------------
module pipe_rr_sched #(
    parameter int N       = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     pipe_in,
    output logic                 pipe_in_vld,
    input  logic [WIDTH-1:0]     pipe_out,
    output logic [N-1:0]         resp_vld,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // ptr_reg holds the index that has the highest priority this cycle.
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // Tag pipeline. Stage 0 is the oldest stage and lines up with pipe_out.
    logic [LATENCY-1:0] tag_vld_reg;
    logic [PTR_W-1:0]   tag_id_reg [LATENCY];

    // -------------------------------------------------------------------------
    // Operand unpacking
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] operand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign operand[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Scan order
    // scan_idx[k] = (ptr + k) mod N. The extra sum bit prevents overflow
    // before the wrap, so this also works when N is not a power of two.
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] scan_idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_scan
            logic [PTR_W:0] sum_full;
            logic [PTR_W:0] sum_wrap;
            assign sum_full = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign sum_wrap = (sum_full >= (PTR_W+1)'(N))
                            ? sum_full - (PTR_W+1)'(N)
                            : sum_full;
            assign scan_idx[gi] = sum_wrap[PTR_W-1:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Winner selection
    // The first requester found in scan order wins. The winner is only
    // meaningful when grant_ok is high; otherwise it defaults to 0.
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] winner;
    logic             winner_found;
    logic             grant_ok;

    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!winner_found && req[scan_idx[k]]) begin
                winner       = scan_idx[k];
                winner_found = 1'b1;
            end
        end
    end

    // Reset masks the grant combinationally, so no operation can issue while
    // rst is high, even though the state registers only clear at the edge.
    assign grant_ok = en && !rst && winner_found;

    // -------------------------------------------------------------------------
    // Grant and issue
    // -------------------------------------------------------------------------
    logic [N-1:0] winner_onehot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign winner_onehot[gi] = (winner == PTR_W'(gi));
        end
    endgenerate

    assign gnt         = grant_ok ? winner_onehot : '0;
    assign pipe_in_vld = grant_ok;
    assign pipe_in     = grant_ok ? operand[winner] : '0;

    // The requester just served drops to the lowest priority.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_ok) begin
            if (winner == PTR_W'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = winner + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline
    // The newest stage (LATENCY-1) captures the issue of this cycle, and every
    // other stage takes the value of the stage above it. A reset drops every
    // tag. The pipe itself has no reset, so its data still comes out, but no
    // response strobe goes with it.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
            if (gi == LATENCY - 1) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        tag_vld_reg[gi] <= 1'b0;
                        tag_id_reg[gi]  <= '0;
                    end else begin
                        tag_vld_reg[gi] <= pipe_in_vld;
                        tag_id_reg[gi]  <= winner;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) begin
                        tag_vld_reg[gi] <= 1'b0;
                        tag_id_reg[gi]  <= '0;
                    end else begin
                        tag_vld_reg[gi] <= tag_vld_reg[gi+1];
                        tag_id_reg[gi]  <= tag_id_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Response routing
    // The strobe is also masked by rst. A response that would land in the
    // reset cycle belongs to an operation that the reset is dropping.
    // -------------------------------------------------------------------------
    logic         resp_live;
    logic [N-1:0] resp_onehot;

    assign resp_live = tag_vld_reg[0] && !rst;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_resp
            assign resp_onehot[gi] = (tag_id_reg[0] == PTR_W'(gi));
        end
    endgenerate

    assign resp_vld  = resp_live ? resp_onehot : '0;
    assign resp_data = pipe_out;

    assign busy = !rst && ((|tag_vld_reg) || pipe_in_vld);

endmodule

// File: tb/tb_pipe_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_pipe_rr_sched
//
// Bench for pipe_rr_sched with N=4, WIDTH=8 and LATENCY=3. The shared pipe is
// a 3-stage delay chain without reset.
//
// A behavioural model tracks the next-priority index and a queue of the
// operations issued in the last LATENCY cycles. A compare process checks every
// DUT output against this model on each negedge. Directed sequences add
// literal expectations that pin the model down.
// -----------------------------------------------------------------------------
module tb_pipe_rr_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   pipe_in;
    logic           pipe_in_vld;
    logic [W-1:0]   pipe_out;
    logic [N-1:0]   resp_vld;
    logic [W-1:0]   resp_data;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_rr_sched #(.N(N), .WIDTH(W), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .pipe_in     (pipe_in),
        .pipe_in_vld (pipe_in_vld),
        .pipe_out    (pipe_out),
        .resp_vld    (resp_vld),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    // Shared pipe: a plain 3-clock delay line without reset.
    logic [W-1:0] chain [LAT];
    always @(posedge clk) begin
        chain[2] <= pipe_in;
        chain[1] <= chain[2];
        chain[0] <= chain[1];
    end
    assign pipe_out = chain[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    typedef struct {
        bit           vld;
        int           id;
        logic [W-1:0] data;
    } op_t;

    int  m_pri = 0;   // requester that has the highest priority next
    op_t m_q[$];      // operations issued in the last LAT cycles, oldest first

    function automatic int m_winner();
        if (rst !== 1'b0 || en !== 1'b1) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_pri + k) % N;
            if (req[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_pri = 0;
            m_q.delete();
        end else begin
            int  w;
            op_t o;
            w      = m_winner();
            o.vld  = (w >= 0);
            o.id   = (w >= 0) ? w : 0;
            o.data = (w >= 0) ? req_data[w*W +: W] : '0;
            m_q.push_back(o);
            if (m_q.size() > LAT) void'(m_q.pop_front());
            if (w >= 0) m_pri = (w + 1) % N;
        end
    end

    always @(negedge clk) begin
        int           w;
        logic [N-1:0] e_gnt;
        logic [W-1:0] e_pin;
        logic [N-1:0] e_resp;
        logic         e_busy;
        w      = m_winner();
        e_gnt  = (w >= 0) ? N'(1 << w) : '0;
        e_pin  = (w >= 0) ? req_data[w*W +: W] : '0;
        e_resp = '0;
        if (rst === 1'b0 && m_q.size() == LAT && m_q[0].vld)
            e_resp = N'(1 << m_q[0].id);
        e_busy = 1'b0;
        if (rst === 1'b0) begin
            e_busy = (w >= 0);
            foreach (m_q[i]) if (m_q[i].vld) e_busy = 1'b1;
        end
        check("model_gnt", 32'(gnt), 32'(e_gnt));
        check("model_pipe_in", 32'(pipe_in), 32'(e_pin));
        check("model_pipe_in_vld", 32'(pipe_in_vld), 32'(w >= 0));
        check("model_resp_vld", 32'(resp_vld), 32'(e_resp));
        check("model_busy", 32'(busy), 32'(e_busy));
        if (e_resp != '0)
            check("model_resp_data", 32'(resp_data), 32'(m_q[0].data));
    end

    // -------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) cyc();
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_resp_vld", 32'(resp_vld), 32'h0);

        // 1: a single operation from requester 2
        cyc();
        rst = 1'b0;
        req = 4'b0100;
        req_data[2*W +: W] = 8'hA5;
        #1;
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_pipe_in", 32'(pipe_in), 32'hA5);
        check("t1_busy0", 32'(busy), 32'h1);
        cyc(); req = '0; #1;
        check("t1_busy1", 32'(busy), 32'h1);
        check("t1_no_gnt", 32'(gnt), 32'h0);
        cyc(); #1;
        check("t1_busy2", 32'(busy), 32'h1);
        cyc(); #1;
        check("t1_busy3", 32'(busy), 32'h1);
        check("t1_resp_vld", 32'(resp_vld), 32'h4);
        check("t1_resp_data", 32'(resp_data), 32'hA5);
        cyc(); #1;
        check("t1_busy4", 32'(busy), 32'h0);
        check("t1_resp_done", 32'(resp_vld), 32'h0);

        // 2: all four requesting for 8 clk, starting from a reset (ptr=0)
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_gnt", 32'(gnt), 32'(1 << (i % 4)));
            check("t2_pipe_in", 32'(pipe_in), 32'(8'h10 + i % 4));
            if (i >= 3) begin
                check("t2_resp_vld", 32'(resp_vld), 32'(1 << ((i - 3) % 4)));
                check("t2_resp_data", 32'(resp_data), 32'(8'h10 + (i - 3) % 4));
            end
            cyc();
        end

        // 3: walk ptr to 2 (last grant to 1), then req=0011 wraps to 0
        req = 4'b0011; #1;
        check("t3_gnt_a", 32'(gnt), 32'h1);
        cyc(); req = 4'b0010; #1;
        check("t3_gnt_b", 32'(gnt), 32'h2);
        cyc(); req = 4'b0011; #1;
        check("t3_wrap", 32'(gnt), 32'h1);
        cyc(); req = 4'b0010; #1;
        check("t3_next", 32'(gnt), 32'h2);

        // 4: en pulsed low for 2 clk while all four request (ptr=2)
        cyc(); req = 4'hF; #1;
        check("t4_gnt0", 32'(gnt), 32'h4);
        cyc(); #1;
        check("t4_gnt1", 32'(gnt), 32'h8);
        cyc(); en = 1'b0; #1;
        check("t4_en0_gnt", 32'(gnt), 32'h0);
        check("t4_en0_vld", 32'(pipe_in_vld), 32'h0);
        check("t4_en0_busy", 32'(busy), 32'h1);
        cyc(); #1;
        check("t4_en0_gnt2", 32'(gnt), 32'h0);
        check("t4_resp_a", 32'(resp_vld), 32'h4);
        cyc(); en = 1'b1; #1;
        check("t4_resume", 32'(gnt), 32'h1);
        check("t4_resume_data", 32'(pipe_in), 32'h10);
        check("t4_resp_b", 32'(resp_vld), 32'h8);
        cyc(); #1;
        check("t4_gnt_next", 32'(gnt), 32'h2);
        check("t4_gap0", 32'(resp_vld), 32'h0);
        cyc(); req = '0; #1;
        check("t4_gap1", 32'(resp_vld), 32'h0);
        repeat (4) cyc();

        // 5: three grants, then rst 1 clk after the last one (ptr=2)
        req = 4'hF; #1;
        check("t5_gnt0", 32'(gnt), 32'h4);
        cyc(); #1;
        check("t5_gnt1", 32'(gnt), 32'h8);
        cyc(); #1;
        check("t5_gnt2", 32'(gnt), 32'h1);
        cyc(); req = '0; rst = 1'b1; #1;
        check("t5_rst_resp", 32'(resp_vld), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        cyc(); rst = 1'b0; #1;
        check("t5_flush_resp1", 32'(resp_vld), 32'h0);
        check("t5_flush_busy1", 32'(busy), 32'h0);
        cyc(); #1;
        check("t5_flush_resp2", 32'(resp_vld), 32'h0);
        check("t5_flush_busy2", 32'(busy), 32'h0);
        cyc(); req = 4'hF; #1;
        check("t5_ptr0", 32'(gnt), 32'h1);
        cyc(); req = '0;

        // 6: idle after reset, with nonzero operands on the inputs
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; req_data = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t6_gnt", 32'(gnt), 32'h0);
            check("t6_pipe_in", 32'(pipe_in), 32'h0);
            check("t6_resp_vld", 32'(resp_vld), 32'h0);
            check("t6_busy", 32'(busy), 32'h0);
            cyc();
        end

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
